// File: rtl/mpx_muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU unit for the MPX core.
// Multiplies retire in 2 cycles and divides in 33 (restoring, one bit per cycle).
module mpx_muldiv (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        opcode_valid_i,
    input  logic [1:0]  op_i,
    input  logic [31:0] operand_ra_i,
    input  logic [31:0] operand_rb_i,
    input  logic        flush_i,
    output logic        busy_o,
    output logic        writeback_valid_o,
    output logic [31:0] writeback_hi_o,
    output logic [31:0] writeback_lo_o
);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t state;
    logic [5:0] cnt;
    logic accept;
    logic is_signed;

    logic signed [32:0] mul_a;
    logic signed [32:0] mul_b;
    logic signed [63:0] prod;

    logic [31:0] ra_q;
    logic [31:0] dvs;
    logic [31:0] rem;
    logic [31:0] quo;
    logic        q_neg;
    logic        r_neg;
    logic        div_zero;

    logic [32:0] part;
    logic        ge;
    logic [31:0] rem_nxt;
    logic [31:0] quo_nxt;

    function automatic logic [31:0] abs_val(input logic [31:0] v);
        return v[31] ? (32'd0 - v) : v;
    endfunction

    function automatic logic [31:0] set_sign(input logic [31:0] v, input logic neg);
        return neg ? (32'd0 - v) : v;
    endfunction

    assign busy_o            = (state == S_MUL) || (state == S_DIV);
    assign accept            = opcode_valid_i && !busy_o && !flush_i;
    assign writeback_valid_o = (state == S_DONE) && !flush_i;
    assign is_signed         = !op_i[0];

    assign prod = mul_a * mul_b;

    // Restoring step: shift the next dividend bit in, subtract when it fits.
    always_comb begin
        part    = {rem, quo[31]};
        ge      = (part >= {1'b0, dvs});
        rem_nxt = part[31:0];
        quo_nxt = {quo[30:0], 1'b0};
        if (ge) begin
            rem_nxt = part[31:0] - dvs;
            quo_nxt = {quo[30:0], 1'b1};
        end
    end

    // Operand and working registers: loaded on accept, shifted while dividing.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            mul_a    <= is_signed ? {operand_ra_i[31], operand_ra_i} : {1'b0, operand_ra_i};
            mul_b    <= is_signed ? {operand_rb_i[31], operand_rb_i} : {1'b0, operand_rb_i};
            ra_q     <= operand_ra_i;
            rem      <= 32'd0;
            quo      <= is_signed ? abs_val(operand_ra_i) : operand_ra_i;
            dvs      <= is_signed ? abs_val(operand_rb_i) : operand_rb_i;
            q_neg    <= is_signed && (operand_ra_i[31] ^ operand_rb_i[31]);
            r_neg    <= is_signed && operand_ra_i[31];
            div_zero <= (operand_rb_i == 32'd0);
        end else if (state == S_DIV) begin
            rem <= rem_nxt;
            quo <= quo_nxt;
        end
    end

    // Control FSM and result registers.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state          <= S_IDLE;
            cnt            <= 6'd0;
            writeback_hi_o <= 32'd0;
            writeback_lo_o <= 32'd0;
        end else if (flush_i) begin
            state <= S_IDLE;
            cnt   <= 6'd0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    cnt <= 6'd0;
                    if (accept) begin
                        state <= op_i[1] ? S_DIV : S_MUL;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_MUL: begin
                    writeback_hi_o <= prod[63:32];
                    writeback_lo_o <= prod[31:0];
                    state          <= S_DONE;
                end
                S_DIV: begin
                    cnt <= cnt + 6'd1;
                    if (cnt == 6'd31) begin
                        cnt   <= 6'd0;
                        state <= S_DONE;
                        if (div_zero) begin
                            writeback_hi_o <= ra_q;
                            writeback_lo_o <= 32'hFFFF_FFFF;
                        end else begin
                            writeback_hi_o <= set_sign(rem_nxt, r_neg);
                            writeback_lo_o <= set_sign(quo_nxt, q_neg);
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mpx_muldiv.sv
// Randomized bench for mpx_muldiv against a plain-arithmetic reference model.
module tb_mpx_muldiv;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        opcode_valid_i = 1'b0;
    logic [1:0]  op_i = 2'd0;
    logic [31:0] operand_ra_i = 32'd0;
    logic [31:0] operand_rb_i = 32'd0;
    logic        flush_i = 1'b0;
    logic        busy_o;
    logic        writeback_valid_o;
    logic [31:0] writeback_hi_o;
    logic [31:0] writeback_lo_o;

    int n_vec = 0;
    int n_err = 0;

    mpx_muldiv dut (
        .clk_i             (clk_i),
        .rst_i             (rst_i),
        .opcode_valid_i    (opcode_valid_i),
        .op_i              (op_i),
        .operand_ra_i      (operand_ra_i),
        .operand_rb_i      (operand_rb_i),
        .flush_i           (flush_i),
        .busy_o            (busy_o),
        .writeback_valid_o (writeback_valid_o),
        .writeback_hi_o    (writeback_hi_o),
        .writeback_lo_o    (writeback_lo_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference result {hi, lo} from the architectural definition.
    function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        longint p;
        int sa, sb, q, r;
        logic [31:0] qq, rr;
        sa = a;
        sb = b;
        case (op)
            2'd0: begin
                p = longint'(sa) * longint'(sb);
                return p;
            end
            2'd1: return {32'd0, a} * {32'd0, b};
            2'd2: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
                q = sa / sb;
                r = sa % sb;
                qq = q;
                rr = r;
                return {rr, qq};
            end
            default: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
        endcase
    endfunction

    task automatic wait_valid(output int n);
        n = 0;
        do begin
            @(posedge clk_i);
            n++;
            @(negedge clk_i);
        end while (!writeback_valid_o && n < 40);
    endtask

    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk_i);
        opcode_valid_i = 1'b1;
        op_i           = op;
        operand_ra_i   = a;
        operand_rb_i   = b;
        @(posedge clk_i);
        #1 opcode_valid_i = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b);
        int n;
        logic [63:0] e;
        e = model(op, a, b);
        issue(op, a, b);
        chk({tag, "_busy"}, 64'(busy_o), 64'd1);
        wait_valid(n);
        chk({tag, "_lat"}, 64'(n), op[1] ? 64'd32 : 64'd1);
        chk({tag, "_res"}, {writeback_hi_o, writeback_lo_o}, e);
        @(posedge clk_i);
        @(negedge clk_i);
        chk({tag, "_pulse"}, 64'(writeback_valid_o), 64'd0);
    endtask

    task automatic count_pulses(input int cycles, output int pulses);
        pulses = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk_i);
            if (writeback_valid_o) pulses++;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time exhausted");
        $fatal(1);
    end

    initial begin
        int n, pulses;
        logic [1:0]  rop;
        logic [31:0] ra, rb;

        #2 rst_i = 1'b0;
        repeat (2) @(negedge clk_i);
        chk("rst_busy",  64'(busy_o), 64'd0);
        chk("rst_valid", 64'(writeback_valid_o), 64'd0);
        chk("rst_res",   {writeback_hi_o, writeback_lo_o}, 64'd0);
        rst_i = 1'b1;

        run_op("mult",  2'd0, 32'hFFFF_FFFE, 32'h0000_0003);
        chk("mult_k", {writeback_hi_o, writeback_lo_o}, 64'hFFFF_FFFF_FFFF_FFFA);
        run_op("multu", 2'd1, 32'hFFFF_FFFE, 32'h0000_0003);
        chk("multu_k", {writeback_hi_o, writeback_lo_o}, 64'h0000_0002_FFFF_FFFA);
        run_op("div",   2'd2, 32'hFFFF_FFF9, 32'h0000_0002);
        chk("div_k", {writeback_hi_o, writeback_lo_o}, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op("divu",  2'd3, 32'd100, 32'd7);
        chk("divu_k", {writeback_hi_o, writeback_lo_o}, {32'd2, 32'd14});
        run_op("divz",  2'd2, 32'h1234_5678, 32'd0);
        chk("divz_k", {writeback_hi_o, writeback_lo_o}, 64'h1234_5678_FFFF_FFFF);
        run_op("divzn", 2'd2, 32'h8765_4321, 32'd0);
        run_op("divuz", 2'd3, 32'hDEAD_BEEF, 32'd0);
        run_op("ovf",   2'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        chk("ovf_k", {writeback_hi_o, writeback_lo_o}, 64'h0000_0000_8000_0000);
        run_op("divneg", 2'd2, 32'd7, 32'hFFFF_FFFE);

        for (int i = 0; i < 40; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: rb = 32'hFFFF_FFFF;
                2: ra = 32'h8000_0000;
                3: rb = $urandom_range(1, 20);
                default: ;
            endcase
            run_op("rnd", rop, ra, rb);
        end

        // Flush ten cycles into a divide.
        issue(2'd2, 32'd1000, 32'd3);
        repeat (9) @(posedge clk_i);
        @(negedge clk_i);
        flush_i = 1'b1;
        @(posedge clk_i);
        #1 flush_i = 1'b0;
        chk("flush_busy", 64'(busy_o), 64'd0);
        count_pulses(40, pulses);
        chk("flush_nowb", 64'(pulses), 64'd0);

        // Flush during the DONE cycle.
        issue(2'd0, 32'd5, 32'd6);
        @(posedge clk_i);
        #1 chk("fdone_pre", 64'(writeback_valid_o), 64'd1);
        flush_i = 1'b1;
        #1 chk("fdone_sup", 64'(writeback_valid_o), 64'd0);
        @(posedge clk_i);
        #1 flush_i = 1'b0;
        count_pulses(5, pulses);
        chk("fdone_nowb", 64'(pulses), 64'd0);

        // Back-to-back: MULTU accepted on the edge that retires a DIVU.
        issue(2'd3, 32'd1000, 32'd7);
        wait_valid(n);
        chk("b2b_divlat", 64'(n), 64'd32);
        chk("b2b_idle", 64'(busy_o), 64'd0);
        chk("b2b_divres", {writeback_hi_o, writeback_lo_o}, {32'd6, 32'd142});
        opcode_valid_i = 1'b1;
        op_i           = 2'd1;
        operand_ra_i   = 32'd3;
        operand_rb_i   = 32'd5;
        @(posedge clk_i);
        #1 opcode_valid_i = 1'b0;
        chk("b2b_acc", 64'(busy_o), 64'd1);
        wait_valid(n);
        chk("b2b_mullat", 64'(n), 64'd1);
        chk("b2b_mulres", {writeback_hi_o, writeback_lo_o}, 64'd15);

        // Asynchronous reset between edges in the middle of a divide.
        issue(2'd2, 32'h7FFF_FFFF, 32'd9);
        repeat (5) @(posedge clk_i);
        #3 rst_i = 1'b0;
        #1;
        chk("arst_busy",  64'(busy_o), 64'd0);
        chk("arst_valid", 64'(writeback_valid_o), 64'd0);
        chk("arst_res",   {writeback_hi_o, writeback_lo_o}, 64'd0);
        @(negedge clk_i);
        rst_i = 1'b1;
        count_pulses(40, pulses);
        chk("arst_nowb", 64'(pulses), 64'd0);
        run_op("arst_mult", 2'd0, 32'd2, 32'd2);
        chk("arst_mult_k", {writeback_hi_o, writeback_lo_o}, 64'd4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mpx_muldiv.md
# mpx_muldiv

Iterative multiply/divide unit for the MPX core, executing MULT, MULTU, DIV and DIVU. It sits directly upstream of the COP0/HI-LO register file. Its one-cycle writeback_valid_o pulse with writeback_hi_o/writeback_lo_o drives that block's muldiv_i, muldiv_hi_i and muldiv_lo_i inputs. busy_o stalls the issue stage while an operation is in flight.

## Interface
Parameters:
- none

Ports:
- clk_i  input  1  core clock; all state updates on rising edge
- rst_i  input  1  reset, asynchronous assert, active-low (0 = reset)
- opcode_valid_i  input  1  issue request; accepted when high and busy_o low
- op_i  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- operand_ra_i  input  32  rs operand (multiplicand / dividend)
- operand_rb_i  input  32  rt operand (multiplier / divisor)
- flush_i  input  1  pipeline kill (exception/interrupt); aborts any operation
- busy_o  output  1  operation in progress; issue must stall
- writeback_valid_o  output  1  one-cycle result pulse (feeds muldiv_i)
- writeback_hi_o  output  32  HI result: product[63:32] or remainder
- writeback_lo_o  output  32  LO result: product[31:0] or quotient

## Operation
- States: IDLE, MUL, DIV, DONE.
- Accept condition: opcode_valid_i && !busy_o && !flush_i, allowed in IDLE or DONE.
  - On accept: latch operands and op.
  - op_i[1]=0 goes to MUL; op_i[1]=1 goes to DIV.
- opcode_valid_i while busy_o=1 is ignored; upstream holds it.
- MUL:
  - Signed (MULT) sign-extends both operands to 33 bits; MULTU zero-extends them.
  - The 64-bit product is registered on the next edge, then the state moves to DONE.
- DIV:
  - Setup on accept: for DIV, take the absolute values of both operands and record quotient sign = ra[31]^rb[31] and remainder sign = ra[31]. DIVU uses the raw values.
  - Restoring divider: one quotient bit per edge, 6-bit counter, 32 iterations.
  - On the final iteration the result is sign-corrected and registered, then the state moves to DONE.
  - Remainder sign always follows the dividend.
- Divide by zero (rb=0, either op): result lo=32'hFFFFFFFF, hi=operand_ra as latched (original signed value). Same latency as a normal divide.
- Signed overflow (0x80000000 / 0xFFFFFFFF): lo=32'h80000000, hi=0.
- DONE:
  - writeback_valid_o = (state==DONE) && !flush_i.
  - Result registers are stable for that cycle.
  - Next state is IDLE unless a new accept occurs (back-to-back issue).
- flush_i:
  - In any state, the next edge forces IDLE and clears the counter.
  - Suppresses writeback_valid_o combinationally in the same cycle.
  - The in-flight result is discarded and never written back.
- writeback_hi_o/writeback_lo_o hold their last value outside DONE. They are only meaningful while writeback_valid_o=1.

## Timing
- Reset (rst_i=0, asynchronous):
  - state=IDLE, counter=0.
  - busy_o=0, writeback_valid_o=0, writeback_hi_o=0, writeback_lo_o=0.
  - Takes effect immediately, including mid-operation; no result is produced for an aborted op.
- Accept edge is E0.
- Multiply:
  - busy_o=1 during cycle E0→E1.
  - writeback_valid_o=1 during cycle E1→E2.
  - Latency is 2 cycles from issue to the writeback pulse.
- Divide:
  - busy_o=1 from E0 through E32; iterations run on E1..E32.
  - writeback_valid_o=1 during cycle E32→E33.
  - Latency is 33 cycles.
- busy_o is low in DONE, so a new op may be accepted on the same edge that retires the result.
- writeback_valid_o is asserted for exactly one cycle per completed, unflushed operation.
- flush_i together with opcode_valid_i in the same cycle: the flush wins, nothing is accepted, and the next state is IDLE.

## Test plan
- MULT 0xFFFFFFFE × 0x00000003 → after 2 cycles, one valid pulse with hi=0xFFFFFFFF, lo=0xFFFFFFFA. MULTU with the same operands → hi=0x00000002, lo=0xFFFFFFFA.
- DIV −7 / 2 (0xFFFFFFF9, 0x00000002) → valid exactly 33 cycles after accept, lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 100/7 → lo=14, hi=2.
- Divide by zero, DIV 0x12345678 / 0 → lo=0xFFFFFFFF, hi=0x12345678. Overflow DIV 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0.
- Flush: assert flush_i at cycle 10 of a DIV → no writeback_valid_o ever for that op; busy_o=0 next cycle. Flush during the DONE cycle → valid stays 0.
- Back-to-back: issue MULTU 3×5 while the previous DIVU retires in DONE → DIVU result pulse, then 2 cycles later hi=0, lo=15; busy_o never blocks the DONE-cycle accept.
- Async reset asserted mid-DIV (between edges) → busy_o and writeback_valid_o go 0 immediately, outputs 0. After release, a MULT 2×2 → hi=0, lo=4.
